// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and default sizing for the register-file write arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_write_arbiter_pkg;

    localparam int RF_COUNT    = 15;  // architectural registers
    localparam int RF_SIZE     = 4;   // register address width
    localparam int RF_LEN      = 32;  // data width
    localparam int RF_DEPTH    = 4;   // load-return FIFO entries
    localparam int RF_MAX_WAIT = 8;   // head wait before a hold is requested

    // One buffered load return. A cleared valid bit means the entry was
    // killed by a younger writeback to the same register.
    typedef struct packed {
        logic              valid;
        logic [RF_SIZE-1:0] dest;
        logic [RF_LEN-1:0]  data;
    } entry_t;

endpackage

// File: rtl/rf_ld_fifo.sv
// Load-return FIFO with per-entry kill-by-destination.
// Latency: push visible at head one cycle after the push edge; no bypass.
// Backpressure: caller must not push when count == DEPTH nor pop when empty.
//
// Ports: clk/rst_n; push/push_dest/push_data; pop; kill/kill_dest clears
// valid on every stored entry whose dest matches; head = entry at read
// pointer; count = occupied slots (killed ones included); slot_valid and
// slot_dest expose all storage for the busy decode.
module rf_ld_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [RF_SIZE-1:0]            push_dest,
    input  logic [RF_LEN-1:0]             push_data,
    input  logic                          pop,
    input  logic                          kill,
    input  logic [RF_SIZE-1:0]            kill_dest,
    output entry_t                        head,
    output logic [CW-1:0]                 count,
    output logic [DEPTH-1:0]              slot_valid,
    output logic [DEPTH-1:0][RF_SIZE-1:0] slot_dest
);

    entry_t           mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [DEPTH-1:0] kill_hit;

    // Unoccupied slots always hold valid=0 (cleared on pop and reset), so
    // the valid bits alone describe the live set without consulting pointers.
    always_comb begin
        kill_hit   = '0;
        slot_valid = '0;
        slot_dest  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_hit[i]   = kill && mem[i].valid && (mem[i].dest == kill_dest);
            slot_valid[i] = mem[i].valid;
            slot_dest[i]  = mem[i].dest;
        end
    end

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_hit[i]) begin
                    mem[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            // Push slot never equals the pop slot: push requires not-full
            // and pop requires not-empty.
            if (push) begin
                mem[wr_ptr] <= '{valid: 1'b1, dest: push_dest, data: push_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between pipeline writeback and
// buffered late load returns; WB has fixed priority.
// Latency: WB write is zero-cycle; a load return writes >= 1 cycle after accept.
// Backpressure: ld_ready drops when the FIFO is full; wb_hold asks the
// pipeline for bubbles when a buffered load has starved.
//
// Ports: clk, rst_n; wb_we/wb_dest/wb_data writeback request;
// ld_valid/ld_ready/ld_dest/ld_data load-return handshake;
// rf_we/rf_dest/rf_data register file write port; busy_mask pending
// buffered writes per register; wb_hold freeze request; fifo_count occupancy.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int COUNT    = RF_COUNT,
    parameter int DEPTH    = RF_DEPTH,
    parameter int MAX_WAIT = RF_MAX_WAIT,
    localparam int SIZE = RF_SIZE,
    localparam int LEN  = RF_LEN,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int WW   = $clog2(MAX_WAIT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_we,
    input  logic [SIZE-1:0] wb_dest,
    input  logic [LEN-1:0]  wb_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [SIZE-1:0] ld_dest,
    input  logic [LEN-1:0]  ld_data,
    output logic            rf_we,
    output logic [SIZE-1:0] rf_dest,
    output logic [LEN-1:0]  rf_data,
    output logic [COUNT-1:0] busy_mask,
    output logic            wb_hold,
    output logic [CW-1:0]   fifo_count
);

    // One extra bit so COUNT == 2**SIZE still compares correctly.
    localparam logic [SIZE:0]   COUNT_W    = (SIZE + 1)'(COUNT);
    localparam logic [CW-1:0]   DEPTH_W    = CW'(DEPTH);
    localparam logic [WW-1:0]   MAX_WAIT_W = WW'(MAX_WAIT);

    entry_t                     head;
    logic [DEPTH-1:0]           slot_valid;
    logic [DEPTH-1:0][SIZE-1:0] slot_dest;
    logic                       wb_legal;
    logic                       ld_legal;
    logic                       nonempty;
    logic                       head_live;
    logic                       pop;
    logic                       push;
    logic [WW-1:0]              wait_cnt;

    assign wb_legal  = wb_we && ({1'b0, wb_dest} < COUNT_W);
    assign ld_legal  = {1'b0, ld_dest} < COUNT_W;
    assign ld_ready  = fifo_count < DEPTH_W;
    assign nonempty  = fifo_count != '0;
    assign head_live = nonempty && head.valid;

    // A killed head is dropped regardless of WB; a live head only drains
    // into cycles without a legal WB write.
    assign pop  = nonempty && (!head.valid || !wb_legal);

    // A load accepted alongside a WB to the same register is older than
    // that WB, so it is dead on arrival and never stored.
    assign push = ld_valid && ld_ready && ld_legal
               && !(wb_legal && (ld_dest == wb_dest));

    assign rf_we   = wb_legal || head_live;
    assign rf_dest = head_live && !wb_legal ? head.dest : wb_dest;
    assign rf_data = head_live && !wb_legal ? head.data : wb_data;

    rf_ld_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_dest (ld_dest),
        .push_data (ld_data),
        .pop       (pop),
        .kill      (wb_legal),
        .kill_dest (wb_dest),
        .head      (head),
        .count     (fifo_count),
        .slot_valid(slot_valid),
        .slot_dest (slot_dest)
    );

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int r = 0; r < COUNT; r++) begin
                if (slot_valid[i] && (slot_dest[i] == SIZE'(r))) begin
                    busy_mask[r] = 1'b1;
                end
            end
        end
    end

    // wait_cnt counts cycles a live head was blocked by WB. Hold is
    // requested one cycle after it saturates and released one cycle after
    // the FIFO is seen empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            wb_hold  <= 1'b0;
        end else begin
            if (head_live && !pop) begin
                if (wait_cnt != MAX_WAIT_W) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
            if (wait_cnt == MAX_WAIT_W) begin
                wb_hold <= 1'b1;
            end else if (!nonempty) begin
                wb_hold <= 1'b0;
            end
        end
    end

endmodule
